// File: rtl/memory_controller_pkg.sv
// Shared encodings for the byte-serial memory controller: access type,
// FSM states, requester grant and the IO address window.
package memory_controller_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam logic [1:0] IO_ADDR_HI = 2'b11;
   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
   typedef enum logic {GRANT_IC = 1'b0, GRANT_LSB = 1'b1} grant_e;
endpackage

// File: rtl/memory_controller.sv
// Owns the byte-wide RAM/IO port: round-robin arbitration between fetch and
// load/store, little-endian byte serialisation, one-cycle completion pulse.
module memory_controller
   import memory_controller_pkg::*;
(
   input  logic                  Sys_clk,
   input  logic                  Sys_rst,
   input  logic                  Sys_rdy,
   input  logic                  RoBMC_pre_judge,
   input  logic                  LSBMC_en,
   input  logic                  LSBMC_wr,
   input  logic [2:0]            LSBMC_data_width,
   input  logic [31:0]           LSBMC_data,
   input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
   output logic                  MCLSB_r_en,
   output logic                  MCLSB_w_en,
   output logic [31:0]           MCLSB_data,
   input  logic                  ICMC_en,
   input  logic [ADDR_WIDTH-1:0] ICMC_addr,
   output logic                  MCIC_en,
   output logic [31:0]           MCIC_data,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);
   state_e                state;
   grant_e                grant, last_grant;
   logic [ADDR_WIDTH-1:0] addr;
   logic [2:0]            width, cnt;
   logic [31:0]           wdata, rdata;
   logic                  lsb_r_q, lsb_w_q, ic_q;
   // a_*: byte index currently on mem_a; d_*: byte index now on mem_din
   logic                  a_vld, d_vld;
   logic [1:0]            a_idx, d_idx;

   logic                  flush, io_stall, ic_abort, last_cap, pick_lsb;
   logic [ADDR_WIDTH-1:0] byte_addr;

   assign flush     = ~RoBMC_pre_judge;
   assign byte_addr = addr + {{(ADDR_WIDTH-3){1'b0}}, cnt};
   assign io_stall  = (addr[17:16] == IO_ADDR_HI) && io_buffer_full;
   assign ic_abort  = flush && (grant == GRANT_IC) && (state == ST_READ || state == ST_DONE);
   assign last_cap  = d_vld && ({1'b0, d_idx} == width - 3'd1);
   assign pick_lsb  = LSBMC_en && (!ICMC_en || last_grant == GRANT_IC);

   assign MCLSB_r_en = lsb_r_q;
   assign MCLSB_w_en = lsb_w_q;
   assign MCIC_en    = ic_q & RoBMC_pre_judge;
   assign MCLSB_data = rdata;
   assign MCIC_data  = rdata;

   always_ff @(posedge Sys_clk) begin
      if (Sys_rst) begin
         state      <= ST_IDLE;
         grant      <= GRANT_IC;
         last_grant <= GRANT_IC;
         addr       <= '0;
         width      <= '0;
         cnt        <= '0;
         wdata      <= '0;
         rdata      <= '0;
         lsb_r_q    <= 1'b0;
         lsb_w_q    <= 1'b0;
         ic_q       <= 1'b0;
         a_vld      <= 1'b0;
         a_idx      <= '0;
         d_vld      <= 1'b0;
         d_idx      <= '0;
         mem_a      <= '0;
         mem_dout   <= '0;
         mem_wr     <= 1'b0;
      end else begin
         lsb_r_q <= 1'b0;
         lsb_w_q <= 1'b0;
         ic_q    <= 1'b0;
         // The RAM's read latency keeps running while frozen, so tracking and
         // capture are ungated; only issue and completion wait for Sys_rdy.
         d_vld   <= a_vld;
         d_idx   <= a_idx;
         if (state == ST_READ && d_vld)
            rdata[{d_idx, 3'b000} +: 8] <= mem_din;

         if (ic_abort) begin
            state <= ST_IDLE;
            a_vld <= 1'b0;
            d_vld <= 1'b0;
         end else if (!Sys_rdy) begin
            mem_wr <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (LSBMC_en || ICMC_en) begin
                  if (LSBMC_en && ICMC_en)
                     last_grant <= pick_lsb ? GRANT_LSB : GRANT_IC;
                  grant <= pick_lsb ? GRANT_LSB : GRANT_IC;
                  addr  <= pick_lsb ? LSBMC_addr : ICMC_addr;
                  width <= pick_lsb ? LSBMC_data_width : 3'd4;
                  wdata <= LSBMC_data;
                  cnt   <= '0;
                  rdata <= '0;
                  a_vld <= 1'b0;
                  d_vld <= 1'b0;
                  state <= (pick_lsb && LSBMC_wr == WRITE) ? ST_WRITE : ST_READ;
               end
               ST_READ: begin
                  if (cnt < width) begin
                     mem_a <= byte_addr;
                     a_vld <= 1'b1;
                     a_idx <= cnt[1:0];
                     cnt   <= cnt + 3'd1;
                  end
                  if (last_cap) begin
                     state <= ST_DONE;
                     a_vld <= 1'b0;
                     if (grant == GRANT_LSB) lsb_r_q <= 1'b1;
                     else                    ic_q    <= 1'b1;
                  end
               end
               ST_WRITE: begin
                  if (cnt < width) begin
                     mem_a    <= byte_addr;
                     mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
                     if (io_stall) begin
                        mem_wr <= 1'b0;
                     end else begin
                        mem_wr <= 1'b1;
                        cnt    <= cnt + 3'd1;
                     end
                  end else begin
                     mem_wr  <= 1'b0;
                     state   <= ST_DONE;
                     lsb_w_q <= 1'b1;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a synchronous byte RAM model.
module tb_memory_controller;
   logic        Sys_clk = 1'b0;
   logic        Sys_rst, Sys_rdy, RoBMC_pre_judge;
   logic        LSBMC_en, LSBMC_wr;
   logic [2:0]  LSBMC_data_width;
   logic [31:0] LSBMC_data, LSBMC_addr;
   logic        MCLSB_r_en, MCLSB_w_en;
   logic [31:0] MCLSB_data;
   logic        ICMC_en;
   logic [31:0] ICMC_addr;
   logic        MCIC_en;
   logic [31:0] MCIC_data;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;

   int errors = 0;
   int checks = 0;

   logic [7:0]  ram [0:262143];
   logic        pl_en;
   logic [17:0] pl_a;
   logic [7:0]  pl_d;

   always #5 Sys_clk = ~Sys_clk;

   always @(posedge Sys_clk) begin
      if (pl_en)       ram[pl_a] <= pl_d;
      else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
   end

   memory_controller dut (
      .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
      .RoBMC_pre_judge(RoBMC_pre_judge),
      .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr), .LSBMC_data_width(LSBMC_data_width),
      .LSBMC_data(LSBMC_data), .LSBMC_addr(LSBMC_addr),
      .MCLSB_r_en(MCLSB_r_en), .MCLSB_w_en(MCLSB_w_en), .MCLSB_data(MCLSB_data),
      .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr), .MCIC_en(MCIC_en), .MCIC_data(MCIC_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   task automatic preload(input logic [17:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(negedge Sys_clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      LSBMC_en = 1'b1; LSBMC_wr = 1'b1; LSBMC_addr = 32'h55; LSBMC_data_width = 3'd1;
      @(negedge Sys_clk);
      @(negedge Sys_clk);
      checks++;
      if ({MCLSB_r_en, MCLSB_w_en, MCIC_en, mem_wr} !== 4'b0)
         begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {MCLSB_r_en, MCLSB_w_en, MCIC_en, mem_wr}); end
      checks++;
      if (mem_a !== 32'h0 || mem_dout !== 8'h0)
         begin errors++; $display("FAIL reset_bus: mem_a=%h mem_dout=%h expected 0", mem_a, mem_dout); end
      checks++;
      if (MCLSB_data !== 32'h0 || MCIC_data !== 32'h0)
         begin errors++; $display("FAIL reset_data: lsb=%h ic=%h expected 0", MCLSB_data, MCIC_data); end
      LSBMC_en = 1'b0;
      Sys_rst = 1'b0;
      @(negedge Sys_clk);
      @(negedge Sys_clk);
   endtask

   task automatic test_lw();
      int done_n = -1, pulses = 0;
      logic [31:0] dat = '0;
      bit ic_bad = 0, wr_bad = 0;
      LSBMC_wr = 1'b0; LSBMC_data_width = 3'd4; LSBMC_addr = 32'h100; LSBMC_data = '0; LSBMC_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge Sys_clk);
         if (n >= 1 && n <= 4) begin
            checks++;
            if (mem_a !== 32'h100 + n - 1)
               begin errors++; $display("FAIL lw_addr%0d: got %h expected %h", n, mem_a, 32'h100 + n - 1); end
         end
         if (MCIC_en) ic_bad = 1;
         if (mem_wr) wr_bad = 1;
         if (MCLSB_r_en) begin
            pulses++;
            if (done_n < 0) begin done_n = n; dat = MCLSB_data; end
            LSBMC_en = 1'b0;
         end
      end
      checks++;
      if (done_n != 6) begin errors++; $display("FAIL lw_latency: got %0d expected 6", done_n); end
      checks++;
      if (dat !== 32'h44332211) begin errors++; $display("FAIL lw_data: got %h expected 44332211", dat); end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL lw_pulses: got %0d expected 1", pulses); end
      checks++;
      if (ic_bad || wr_bad) begin errors++; $display("FAIL lw_side: ic=%0d wr=%0d expected 0 0", ic_bad, wr_bad); end
   endtask

   task automatic test_sb();
      int done_n = -1, pulses = 0, wrs = 0, wr_n = -1;
      logic [31:0] wa = '0;
      logic [7:0]  wd = '0;
      LSBMC_wr = 1'b1; LSBMC_data_width = 3'd1; LSBMC_addr = 32'h200; LSBMC_data = 32'hABCD12EF; LSBMC_en = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge Sys_clk);
         if (mem_wr) begin wrs++; wr_n = n; wa = mem_a; wd = mem_dout; end
         if (MCLSB_w_en) begin
            pulses++;
            if (done_n < 0) done_n = n;
            LSBMC_en = 1'b0;
         end
      end
      checks++;
      if (wrs != 1 || wr_n != 1) begin errors++; $display("FAIL sb_wrcycles: got %0d at %0d expected 1 at 1", wrs, wr_n); end
      checks++;
      if (wa !== 32'h200 || wd !== 8'hEF) begin errors++; $display("FAIL sb_bus: got %h/%h expected 00000200/ef", wa, wd); end
      checks++;
      if (done_n != 2 || pulses != 1) begin errors++; $display("FAIL sb_done: got n=%0d pulses=%0d expected 2 1", done_n, pulses); end
      checks++;
      if (ram[18'h200] !== 8'hEF || ram[18'h201] !== 8'h77)
         begin errors++; $display("FAIL sb_ram: got %h %h expected ef 77", ram[18'h200], ram[18'h201]); end
   endtask

   task automatic test_arb();
      int nl = -1, ni = -1;
      logic [31:0] dl = '0, di = '0;
      LSBMC_wr = 1'b0; LSBMC_data_width = 3'd1; LSBMC_addr = 32'h103; LSBMC_en = 1'b1;
      ICMC_addr = 32'h0; ICMC_en = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge Sys_clk);
         if (MCLSB_r_en) begin if (nl < 0) begin nl = n; dl = MCLSB_data; end LSBMC_en = 1'b0; end
         if (MCIC_en)    begin if (ni < 0) begin ni = n; di = MCIC_data;  end ICMC_en  = 1'b0; end
      end
      checks++;
      if (nl != 3 || dl !== 32'h44) begin errors++; $display("FAIL arb1_lsb: got n=%0d data=%h expected 3 00000044", nl, dl); end
      checks++;
      if (ni != 11 || di !== 32'h00000513) begin errors++; $display("FAIL arb1_ic: got n=%0d data=%h expected 11 00000513", ni, di); end
      nl = -1; ni = -1;
      LSBMC_addr = 32'h100; LSBMC_en = 1'b1;
      ICMC_addr = 32'h80; ICMC_en = 1'b1;
      for (int n = 0; n < 16; n++) begin
         @(negedge Sys_clk);
         if (MCLSB_r_en) begin if (nl < 0) begin nl = n; dl = MCLSB_data; end LSBMC_en = 1'b0; end
         if (MCIC_en)    begin if (ni < 0) begin ni = n; di = MCIC_data;  end ICMC_en  = 1'b0; end
      end
      checks++;
      if (ni != 6 || di !== 32'h12345678) begin errors++; $display("FAIL arb2_ic: got n=%0d data=%h expected 6 12345678", ni, di); end
      checks++;
      if (nl != 11 || dl !== 32'h11) begin errors++; $display("FAIL arb2_lsb: got n=%0d data=%h expected 11 00000011", nl, dl); end
   endtask

   task automatic test_flush();
      int done_n = -1, pulses = 0;
      logic [31:0] dat = '0;
      ICMC_addr = 32'h40; ICMC_en = 1'b1;
      for (int n = 0; n < 16; n++) begin
         @(negedge Sys_clk);
         if (n == 2) begin
            checks++;
            if (mem_a !== 32'h41) begin errors++; $display("FAIL flush_addr: got %h expected 00000041", mem_a); end
            RoBMC_pre_judge = 1'b0; ICMC_en = 1'b0;
         end
         if (n == 3) begin RoBMC_pre_judge = 1'b1; ICMC_addr = 32'h80; ICMC_en = 1'b1; end
         if (n == 5) begin
            checks++;
            if (mem_a !== 32'h80) begin errors++; $display("FAIL flush_refetch_addr: got %h expected 00000080", mem_a); end
         end
         if (MCIC_en) begin
            pulses++;
            if (done_n < 0) begin done_n = n; dat = MCIC_data; end
            ICMC_en = 1'b0;
         end
      end
      checks++;
      if (pulses != 1 || done_n != 10) begin errors++; $display("FAIL flush_done: got pulses=%0d n=%0d expected 1 10", pulses, done_n); end
      checks++;
      if (dat !== 32'h12345678) begin errors++; $display("FAIL flush_data: got %h expected 12345678", dat); end
   endtask

   task automatic test_io_stall();
      int done_n = -1, pulses = 0, wrs = 0, wr_n = -1;
      logic [31:0] wa = '0;
      logic [7:0]  wd = '0;
      LSBMC_wr = 1'b1; LSBMC_data_width = 3'd1; LSBMC_addr = 32'h30000; LSBMC_data = 32'h5A; LSBMC_en = 1'b1;
      io_buffer_full = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge Sys_clk);
         if (n == 3) io_buffer_full = 1'b0;
         if (mem_wr) begin wrs++; wr_n = n; wa = mem_a; wd = mem_dout; end
         if (MCLSB_w_en) begin
            pulses++;
            if (done_n < 0) done_n = n;
            LSBMC_en = 1'b0;
         end
      end
      checks++;
      if (wrs != 1 || wr_n != 4) begin errors++; $display("FAIL io_wrcycles: got %0d at %0d expected 1 at 4", wrs, wr_n); end
      checks++;
      if (wa !== 32'h30000 || wd !== 8'h5A) begin errors++; $display("FAIL io_bus: got %h/%h expected 00030000/5a", wa, wd); end
      checks++;
      if (done_n != 5 || pulses != 1) begin errors++; $display("FAIL io_done: got n=%0d pulses=%0d expected 5 1", done_n, pulses); end
   endtask

   task automatic test_rdy_stall();
      int done_n = -1, pulses = 0;
      logic [31:0] dat = '0;
      bit wr_bad = 0;
      LSBMC_wr = 1'b0; LSBMC_data_width = 3'd2; LSBMC_addr = 32'h10; LSBMC_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge Sys_clk);
         if (n == 1) Sys_rdy = 1'b0;
         if (n == 3) begin
            checks++;
            if (mem_a !== 32'h10) begin errors++; $display("FAIL rdy_hold_addr: got %h expected 00000010", mem_a); end
            Sys_rdy = 1'b1;
         end
         if (mem_wr) wr_bad = 1;
         if (MCLSB_r_en) begin
            pulses++;
            if (done_n < 0) begin done_n = n; dat = MCLSB_data; end
            LSBMC_en = 1'b0;
         end
      end
      checks++;
      if (done_n != 6 || pulses != 1) begin errors++; $display("FAIL rdy_done: got n=%0d pulses=%0d expected 6 1", done_n, pulses); end
      checks++;
      if (dat !== 32'h0000ABCD) begin errors++; $display("FAIL rdy_data: got %h expected 0000abcd", dat); end
      checks++;
      if (wr_bad) begin errors++; $display("FAIL rdy_memwr: got 1 expected 0"); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      LSBMC_wr = 1'b0; LSBMC_data_width = 3'd4; LSBMC_addr = 32'h100; LSBMC_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(negedge Sys_clk);
         if (n == 2) Sys_rst = 1'b1;
         if (n == 3) begin
            checks++;
            if (mem_a !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h expected 00000000", mem_a); end
            Sys_rst = 1'b0; LSBMC_en = 1'b0;
         end
         if (MCLSB_r_en || MCIC_en || MCLSB_w_en) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
   endtask

   initial begin
      Sys_rst = 1'b1; Sys_rdy = 1'b1; RoBMC_pre_judge = 1'b1;
      LSBMC_en = 1'b0; LSBMC_wr = 1'b0; LSBMC_data_width = 3'd0; LSBMC_data = '0; LSBMC_addr = '0;
      ICMC_en = 1'b0; ICMC_addr = '0; io_buffer_full = 1'b0;
      pl_en = 1'b0; pl_a = '0; pl_d = '0;
      @(negedge Sys_clk);
      preload(18'h100, 8'h11); preload(18'h101, 8'h22); preload(18'h102, 8'h33); preload(18'h103, 8'h44);
      preload(18'h200, 8'h00); preload(18'h201, 8'h77);
      preload(18'h000, 8'h13); preload(18'h001, 8'h05); preload(18'h002, 8'h00); preload(18'h003, 8'h00);
      preload(18'h040, 8'h01); preload(18'h041, 8'h02); preload(18'h042, 8'h03); preload(18'h043, 8'h04);
      preload(18'h080, 8'h78); preload(18'h081, 8'h56); preload(18'h082, 8'h34); preload(18'h083, 8'h12);
      preload(18'h010, 8'hCD); preload(18'h011, 8'hAB); preload(18'h012, 8'hFF);
      test_reset();
      test_lw();
      test_sb();
      test_arb();
      test_flush();
      test_io_stall();
      test_rdy_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
